aes_key_sched_ctrl: RTL and testbench

//  Iterative AES key-schedule sequencer. Accepts an NK-word cipher key on a start handshake.

---
 rtl/aes_key_sched_ctrl_if.sv | 23 ++
 rtl/aes_key_sched_ctrl.sv | 160 ++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake and round-key read bus between the key-schedule sequencer and its user.
// The master drives requests and read indices; the slave (sequencer) returns status and key data.
interface aes_key_sched_ctrl_if #(
  parameter int NK = 8
);
  logic              start;
  logic [32*NK-1:0]  key_in;
  logic              busy;
  logic              done;
  logic              key_valid;
  logic [3:0]        rk_rd_round;
  logic [127:0]      rk_rd_data;

  modport master (
    output start, key_in, rk_rd_round,
    input  busy, done, key_valid, rk_rd_data
  );

  modport slave (
    input  start, key_in, rk_rd_round,
    output busy, done, key_valid, rk_rd_data
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key-schedule sequencer: one expanded word per clock into a word store,
// using a single shared SubWord and a running Rcon; round keys are read combinationally.
module aes_key_sched_ctrl #(
  parameter int NK = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  aes_key_sched_ctrl_if.slave        bus
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);
  localparam int PW = $clog2(NK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
  localparam logic [PW-1:0] LAST_PH  = PW'(NK - 1);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {S_IDLE, S_EXPAND} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_w [NW];
  logic [IW-1:0]   r_idx;
  logic [PW-1:0]   r_phase;
  logic [7:0]      r_rcon;
  logic            r_busy;
  logic            r_done;
  logic            r_key_valid;

  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic [IW-1:0]   w_prev_idx;
  logic [IW-1:0]   w_old_idx;
  logic [31:0]     w_prev;
  logic [31:0]     w_old;
  logic [31:0]     w_sub;
  logic [31:0]     w_f;
  logic [31:0]     w_new;
  logic [IW-1:0]   w_rd_base;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_phase tracks i mod NK so no divider is needed; the S-box is shared between both SubWord cases
  always_comb begin
    w_prev_idx = r_idx - IW'(1);
    w_old_idx  = r_idx - IW'(NK);
    w_prev     = r_w[w_prev_idx];
    w_old      = r_w[w_old_idx];
    w_sub      = sub_word((r_phase == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    if (r_phase == '0) begin
      w_f = w_sub ^ {r_rcon, 24'h0};
    end else if ((NK == 8) && (int'(r_phase) == 4)) begin
      w_f = w_sub;
    end else begin
      w_f = w_prev;
    end
    w_new = w_old ^ w_f;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_phase     <= '0;
      r_rcon      <= 8'h01;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_accept) begin
        r_idx       <= IW'(NK);
        r_phase     <= '0;
        r_rcon      <= 8'h01;
        r_busy      <= 1'b1;
        r_key_valid <= 1'b0;
      end else if (w_step) begin
        r_idx   <= r_idx + IW'(1);
        r_phase <= (r_phase == LAST_PH) ? '0 : r_phase + PW'(1);
        if (r_phase == '0) begin
          r_rcon <= xtime(r_rcon);
        end
        if (w_last) begin
          r_busy      <= 1'b0;
          r_key_valid <= 1'b1;
        end
      end
    end
  end

  // Store carries no reset: its contents only matter once key_valid is set
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < NK; k++) begin
        r_w[k] <= bus.key_in[32*(NK-1-k) +: 32];
      end
    end else if (w_step) begin
      r_w[r_idx] <= w_new;
    end
  end

  always_comb begin
    w_rd_base = IW'({bus.rk_rd_round, 2'b00});
    if (r_key_valid && (int'(bus.rk_rd_round) <= NR)) begin
      bus.rk_rd_data = {r_w[w_rd_base], r_w[w_rd_base + IW'(1)],
                        r_w[w_rd_base + IW'(2)], r_w[w_rd_base + IW'(3)]};
    end else begin
      bus.rk_rd_data = '0;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.key_valid = r_key_valid;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: three instances (NK=4/6/8) driven with FIPS-197 vectors;
// a monitor pops the expected schedule on every done pulse and reads the round keys back.
module tb_aes_key_sched_ctrl;
  localparam int NI = 3;

  localparam logic [255:0] KEY4 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEYX = 256'hdeadbeef00112233445566778899aabbccddeeff0123456789abcdeffedcba98;
  localparam logic [127:0] FULL  = {128{1'b1}};
  localparam logic [127:0] TOP32 = {32'hffffffff, 96'h0};
  localparam logic [127:0] TOP96 = {96'hffffffff_ffffffff_ffffffff, 32'h0};

  typedef struct packed {
    int                g;
    int                sc;
    int                lat;
    int                n;
    logic [3:0][3:0]   rnd;
    logic [3:0][127:0] dat;
    logic [3:0][127:0] msk;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NI-1:0]    start_r;
  logic [255:0]     key_r [NI];
  logic [3:0]       rd_r [NI];
  logic [NI-1:0]    busy_v;
  logic [NI-1:0]    done_v;
  logic [NI-1:0]    kv_v;
  logic [127:0]     rd_v [NI];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mon_cnt = 0;
  exp_t sb_q[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NKG = 4 + 2 * g;
    aes_key_sched_ctrl_if #(.NK(NKG)) bus ();
    assign bus.start       = start_r[g];
    assign bus.key_in      = key_r[g][32*NKG-1:0];
    assign bus.rk_rd_round = rd_r[g];
    assign busy_v[g]       = bus.busy;
    assign done_v[g]       = bus.done;
    assign kv_v[g]         = bus.key_valid;
    assign rd_v[g]         = bus.rk_rd_data;
    aes_key_sched_ctrl #(.NK(NKG)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t add_rd(input exp_t e0, input logic [3:0] r, input logic [127:0] d,
                                  input logic [127:0] m);
    exp_t e = e0;
    e.rnd[e.n] = r;
    e.dat[e.n] = d;
    e.msk[e.n] = m;
    e.n = e.n + 1;
    return e;
  endfunction

  function automatic exp_t exp4(input int sc);
    exp_t e = '0;
    e.g = 0; e.sc = sc; e.lat = 40;
    e = add_rd(e, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, FULL);
    e = add_rd(e, 4'd11, 128'h0, FULL);
    e = add_rd(e, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, FULL);
    e = add_rd(e, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, FULL);
    return e;
  endfunction

  function automatic exp_t exp6(input int sc);
    exp_t e = '0;
    e.g = 1; e.sc = sc; e.lat = 46;
    e = add_rd(e, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, FULL);
    e = add_rd(e, 4'd13, 128'h0, FULL);
    e = add_rd(e, 4'd1,  {96'h62f8ead2522c6b7bfe0c91f7, 32'h0}, TOP96);
    e = add_rd(e, 4'd12, 128'he98ba06f448c773c8ecc720401002202, FULL);
    return e;
  endfunction

  function automatic exp_t exp8(input int sc);
    exp_t e = '0;
    e.g = 2; e.sc = sc; e.lat = 52;
    e = add_rd(e, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, FULL);
    e = add_rd(e, 4'd15, 128'h0, FULL);
    e = add_rd(e, 4'd2,  {32'h9ba35411, 96'h0}, TOP32);
    e = add_rd(e, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, FULL);
    return e;
  endfunction

  task automatic check_done(input int g);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: inst %0d got done with empty scoreboard", g);
      return;
    end
    e = sb_q.pop_front();
    chk($sformatf("done_inst%0d", g), 128'(g), 128'(e.g));
    chk($sformatf("latency%0d", g), 128'(cyc - e.sc), 128'(e.lat));
    chk($sformatf("kv_at_done%0d", g), 128'(kv_v[g]), 128'd1);
    for (int k = 0; k < e.n; k++) begin
      rd_r[g] = e.rnd[k];
      #1;
      chk($sformatf("rk%0d_round%0d", g, e.rnd[k]), rd_v[g] & e.msk[k], e.dat[k] & e.msk[k]);
    end
    mon_cnt++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (done_v[g] === 1'b1) check_done(g);
      end
    end
  end

  task automatic do_start(input int g, input logic [255:0] key, output int sc);
    @(negedge clk);
    key_r[g]   = key;
    start_r[g] = 1'b1;
    @(posedge clk);
    #1;
    sc = cyc;
    start_r[g] = 1'b0;
    chk($sformatf("busy_after_start%0d", g), 128'(busy_v[g]), 128'd1);
    chk($sformatf("kv_after_start%0d", g), 128'(kv_v[g]), 128'd0);
  endtask

  task automatic wait_mon(input int target, input int budget);
    int n = 0;
    while (mon_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (mon_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d completions required %0d", mon_cnt, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time budget, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int base;
    int bz;
    rst_n   = 1'b0;
    start_r = '0;
    for (int g = 0; g < NI; g++) begin
      key_r[g] = '0;
      rd_r[g]  = 4'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_busy%0d", g), 128'(busy_v[g]), 128'd0);
      chk($sformatf("rst_done%0d", g), 128'(done_v[g]), 128'd0);
      chk($sformatf("rst_kv%0d", g), 128'(kv_v[g]), 128'd0);
      chk($sformatf("rst_rd%0d", g), rd_v[g], 128'd0);
    end
    rst_n = 1'b1;

    // AES-128, AES-192, AES-256 single runs
    base = mon_cnt;
    do_start(0, KEY4, sc);
    sb_q.push_back(exp4(sc));
    wait_mon(base + 1, 60);

    base = mon_cnt;
    do_start(1, KEY6, sc);
    sb_q.push_back(exp6(sc));
    wait_mon(base + 1, 70);

    base = mon_cnt;
    do_start(2, KEY8, sc);
    sb_q.push_back(exp8(sc));
    wait_mon(base + 1, 80);

    // second start with a different key during expansion must be ignored
    base = mon_cnt;
    do_start(0, KEY4, sc);
    sb_q.push_back(exp4(sc));
    bz = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_v[0] === 1'b1) bz++;
      if (c == 5) begin
        key_r[0]   = KEYX;
        start_r[0] = 1'b1;
      end
      if (c == 6) start_r[0] = 1'b0;
    end
    chk("busy_full_count", 128'(bz), 128'd40);
    wait_mon(base + 1, 20);

    // reset in the middle of an expansion aborts it
    do_start(2, KEY8, sc);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 128'(busy_v[2]), 128'd0);
    chk("midrst_done", 128'(done_v[2]), 128'd0);
    chk("midrst_kv", 128'(kv_v[2]), 128'd0);
    chk("midrst_rd", rd_v[2], 128'd0);
    base = mon_cnt;
    do_start(2, KEY8, sc);
    sb_q.push_back(exp8(sc));
    wait_mon(base + 1, 80);

    // start held high: re-accepted on the edge right after done
    base = mon_cnt;
    @(negedge clk);
    key_r[1]   = KEY6;
    start_r[1] = 1'b1;
    @(posedge clk);
    #1;
    sc = cyc;
    sb_q.push_back(exp6(sc));
    sb_q.push_back(exp6(sc + 47));
    wait_mon(base + 1, 70);
    #1;
    chk("b2b_kv_fall", 128'(kv_v[1]), 128'd0);
    chk("b2b_busy", 128'(busy_v[1]), 128'd1);
    start_r[1] = 1'b0;
    wait_mon(base + 2, 70);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
